// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking request front-end: queued request
// layout, dispatch states, mode encodings and BCD plate validation.
package parking_pkg;

    localparam int PLATE_W = 16;
    localparam int DIGITS  = PLATE_W / 4;

    localparam logic MODE_IN  = 1'b0;
    localparam logic MODE_OUT = 1'b1;

    typedef struct packed {
        logic               mode;
        logic [PLATE_W-1:0] plate;
    } req_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } disp_state_t;

    // A plate is usable only if it is non-zero and every nibble is a decimal digit.
    function automatic logic bcd_valid(input logic [PLATE_W-1:0] plate);
        logic ok;
        ok = (plate != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if (plate[i*4 +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/request_fifo.sv
// Small request FIFO with same-cycle push/pop; count, full and empty are registered.
module request_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_data,
    output logic [WIDTH-1:0]             o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_pop_ok;
    logic             w_push_ok;
    logic [CW-1:0]    w_count_next;

    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign w_pop_ok  = i_pop && !r_empty;
    assign w_push_ok = i_push && (!r_full || w_pop_ok);

    always_comb begin
        w_count_next = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CW'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/parking_request_queue.sv
// Request front-end for the parking controller: de-duplicates and validates operator
// requests, queues them, issues one at a time, and forwards leakage alarms directly.
module parking_request_queue
    import parking_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [PLATE_W-1:0]           license_plate,
    input  logic                         in_mode,
    input  logic                         out_mode,
    input  logic                         leakage,
    input  logic [2:0]                   leakage_floor,
    input  logic                         ctrl_ready,
    output logic                         in_mode_internal,
    output logic                         out_mode_internal,
    output logic [PLATE_W-1:0]           license_plate_internal,
    output logic                         leak_req,
    output logic [2:0]                   leak_floor_out,
    output logic [$clog2(DEPTH+1)-1:0]   queue_count,
    output logic                         queue_full,
    output logic                         drop_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    // Input history for edge detection
    logic               r_prev_req;
    logic               r_prev_mode;
    logic [PLATE_W-1:0] r_prev_plate;
    logic               r_prev_leak;
    logic [2:0]         r_prev_floor;

    disp_state_t        r_state;
    disp_state_t        w_state_next;
    logic [TW-1:0]      r_timer;
    logic [TW-1:0]      w_timer_next;
    logic               r_busy_seen;
    logic               w_busy_next;

    logic               r_in_int;
    logic               r_out_int;
    logic [PLATE_W-1:0] r_plate_int;
    logic               r_leak_req;
    logic [2:0]         r_leak_floor;
    logic               r_drop_err;

    logic               w_req_level;
    logic               w_new_req;
    logic               w_plate_ok;
    logic               w_push;
    logic               w_pop;
    logic               w_leak_event;
    logic               w_leak_ok;
    logic               w_drop;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    req_t               w_push_req;
    req_t               w_head;

    // A held level re-enqueues only when the mode or plate changes.
    assign w_req_level = in_mode ^ out_mode;
    assign w_new_req   = w_req_level &&
                         (!r_prev_req || (out_mode != r_prev_mode) || (license_plate != r_prev_plate));
    assign w_plate_ok  = bcd_valid(license_plate);
    assign w_push      = w_new_req && w_plate_ok;
    assign w_push_req  = '{mode: out_mode, plate: license_plate};

    assign w_leak_event = leakage && (!r_prev_leak || (leakage_floor != r_prev_floor));
    assign w_leak_ok    = w_leak_event && (leakage_floor != 3'd0);

    assign w_drop = (in_mode && out_mode)
                 || (w_new_req && !w_plate_ok)
                 || (w_push && w_fifo_full && !w_pop)
                 || (w_leak_event && (leakage_floor == 3'd0));

    request_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(req_t))
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_req),
        .o_data  (w_head),
        .o_count (queue_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // The timeout exit happens on the edge where the timer would reach TIMEOUT.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_timer_next = r_timer;
        w_busy_next  = r_busy_seen;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty && ctrl_ready && !w_leak_event) begin
                    w_pop        = 1'b1;
                    w_state_next = WAIT;
                    w_timer_next = '0;
                    w_busy_next  = 1'b0;
                end
            end
            WAIT: begin
                w_busy_next = r_busy_seen || !ctrl_ready;
                if (r_busy_seen && ctrl_ready) begin
                    w_state_next = IDLE;
                end else if (!w_busy_next && (r_timer == TW'(TIMEOUT - 1))) begin
                    w_state_next = IDLE;
                end else if (!w_busy_next) begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_timer      <= '0;
            r_busy_seen  <= 1'b0;
            r_prev_req   <= 1'b0;
            r_prev_mode  <= 1'b0;
            r_prev_plate <= '0;
            r_prev_leak  <= 1'b0;
            r_prev_floor <= 3'd0;
            r_in_int     <= 1'b0;
            r_out_int    <= 1'b0;
            r_plate_int  <= '0;
            r_leak_req   <= 1'b0;
            r_leak_floor <= 3'd0;
            r_drop_err   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_timer      <= w_timer_next;
            r_busy_seen  <= w_busy_next;
            r_prev_req   <= w_req_level;
            r_prev_mode  <= out_mode;
            r_prev_plate <= license_plate;
            r_prev_leak  <= leakage;
            r_prev_floor <= leakage_floor;
            r_in_int     <= w_pop && (w_head.mode == MODE_IN);
            r_out_int    <= w_pop && (w_head.mode == MODE_OUT);
            r_plate_int  <= w_pop ? w_head.plate : '0;
            r_leak_req   <= w_leak_ok;
            if (w_leak_ok) begin
                r_leak_floor <= leakage_floor;
            end
            r_drop_err   <= w_drop;
        end
    end

    assign in_mode_internal       = r_in_int;
    assign out_mode_internal      = r_out_int;
    assign license_plate_internal = r_plate_int;
    assign leak_req               = r_leak_req;
    assign leak_floor_out         = r_leak_floor;
    assign queue_full             = w_fifo_full;
    assign drop_err               = r_drop_err;

endmodule

// File: tb/tb_parking_request_queue.sv
// Directed bench for parking_request_queue: queueing, dispatch, de-dup, leakage,
// validation, timeout and reset behaviour with hand-computed expectations.
module tb_parking_request_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] license_plate = 16'h0;
    logic        in_mode = 1'b0;
    logic        out_mode = 1'b0;
    logic        leakage = 1'b0;
    logic [2:0]  leakage_floor = 3'd0;
    logic        ctrl_ready = 1'b0;
    logic        in_mode_internal;
    logic        out_mode_internal;
    logic [15:0] license_plate_internal;
    logic        leak_req;
    logic [2:0]  leak_floor_out;
    logic [2:0]  queue_count;
    logic        queue_full;
    logic        drop_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] fill_a [4] = '{16'h9423, 16'h8754, 16'h9706, 16'h2666};
    logic [15:0] fill_b [4] = '{16'h1001, 16'h1002, 16'h1003, 16'h1004};

    parking_request_queue #(.DEPTH(4), .TIMEOUT(15)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .license_plate          (license_plate),
        .in_mode                (in_mode),
        .out_mode               (out_mode),
        .leakage                (leakage),
        .leakage_floor          (leakage_floor),
        .ctrl_ready             (ctrl_ready),
        .in_mode_internal       (in_mode_internal),
        .out_mode_internal      (out_mode_internal),
        .license_plate_internal (license_plate_internal),
        .leak_req               (leak_req),
        .leak_floor_out         (leak_floor_out),
        .queue_count            (queue_count),
        .queue_full             (queue_full),
        .drop_err               (drop_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({in_mode_internal, out_mode_internal, leak_req, queue_full, drop_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {in_mode_internal, out_mode_internal, leak_req, queue_full, drop_err});
        end
        checks++;
        if (queue_count !== 3'd0 || license_plate_internal !== 16'h0 || leak_floor_out !== 3'd0) begin
            errors++;
            $display("FAIL reset_values: count %0d plate %h floor %0d expected 0 0000 0",
                     queue_count, license_plate_internal, leak_floor_out);
        end
        reset = 1'b1;
        tick();
        $display("reset: count=%0d", queue_count);
    endtask

    task automatic test_fill();
        ctrl_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            license_plate = fill_a[i];
            in_mode = 1'b1;
            tick();
            checks++;
            if (queue_count !== 3'(i + 1) || drop_err !== 1'b0) begin
                errors++;
                $display("FAIL fill_%0d: count %0d drop %b expected %0d 0", i, queue_count, drop_err, i + 1);
            end
            $display("fill: plate=%h count=%0d", fill_a[i], queue_count);
            in_mode = 1'b0;
            tick();
        end
        checks++;
        if (queue_full !== 1'b1) begin
            errors++;
            $display("FAIL fill_full: got %b expected 1", queue_full);
        end
        license_plate = 16'h7723;
        in_mode = 1'b1;
        tick();
        checks++;
        if (drop_err !== 1'b1 || queue_count !== 3'd4) begin
            errors++;
            $display("FAIL overflow_drop: drop %b count %0d expected 1 4", drop_err, queue_count);
        end
        $display("overflow: plate=7723 drop=%b", drop_err);
        in_mode = 1'b0;
        tick();
        checks++;
        if (drop_err !== 1'b0) begin
            errors++;
            $display("FAIL overflow_drop_pulse: got %b expected 0", drop_err);
        end
    endtask

    task automatic test_dispatch();
        ctrl_ready = 1'b1;
        tick();
        checks++;
        if (in_mode_internal !== 1'b1 || out_mode_internal !== 1'b0 ||
            license_plate_internal !== 16'h9423 || queue_count !== 3'd3 || queue_full !== 1'b0) begin
            errors++;
            $display("FAIL issue_first: in %b out %b plate %h count %0d full %b expected 1 0 9423 3 0",
                     in_mode_internal, out_mode_internal, license_plate_internal, queue_count, queue_full);
        end
        $display("issue: plate=%h in=%b", license_plate_internal, in_mode_internal);
        ctrl_ready = 1'b0;
        tick();
        checks++;
        if (in_mode_internal !== 1'b0 || license_plate_internal !== 16'h0) begin
            errors++;
            $display("FAIL issue_one_cycle: in %b plate %h expected 0 0000", in_mode_internal, license_plate_internal);
        end
        tick();
        ctrl_ready = 1'b1;
        tick();
        checks++;
        if (in_mode_internal !== 1'b0) begin
            errors++;
            $display("FAIL wait_exit_no_issue: got %b expected 0", in_mode_internal);
        end
        tick();
        checks++;
        if (in_mode_internal !== 1'b1 || license_plate_internal !== 16'h8754 || queue_count !== 3'd2) begin
            errors++;
            $display("FAIL issue_second: in %b plate %h count %0d expected 1 8754 2",
                     in_mode_internal, license_plate_internal, queue_count);
        end
        $display("issue: plate=%h in=%b", license_plate_internal, in_mode_internal);
        ctrl_ready = 1'b0;
        tick();
    endtask

    task automatic test_hold_out();
        license_plate = 16'h8754;
        out_mode = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (queue_count !== 3'd3 || drop_err !== 1'b0) begin
                errors++;
                $display("FAIL hold_out_%0d: count %0d drop %b expected 3 0", c, queue_count, drop_err);
            end
        end
        out_mode = 1'b0;
        tick();
        $display("hold out_mode 5 cycles: count=%0d", queue_count);
    endtask

    task automatic test_leak_wait();
        leakage = 1'b1;
        leakage_floor = 3'd1;
        for (int c = 0; c < 7; c++) begin
            tick();
            checks++;
            if (leak_req !== (c == 0) || leak_floor_out !== 3'd1) begin
                errors++;
                $display("FAIL leak_hold_%0d: req %b floor %0d expected %b 1", c, leak_req, leak_floor_out, (c == 0));
            end
            checks++;
            if (in_mode_internal !== 1'b0 || out_mode_internal !== 1'b0 || queue_count !== 3'd3) begin
                errors++;
                $display("FAIL leak_fsm_%0d: in %b out %b count %0d expected 0 0 3",
                         c, in_mode_internal, out_mode_internal, queue_count);
            end
        end
        $display("leak floor 1 held 7 cycles: floor_out=%0d", leak_floor_out);
        leakage = 1'b0;
        tick();
        leakage = 1'b1;
        leakage_floor = 3'd0;
        tick();
        checks++;
        if (drop_err !== 1'b1 || leak_req !== 1'b0 || leak_floor_out !== 3'd1) begin
            errors++;
            $display("FAIL leak_floor0: drop %b req %b floor %0d expected 1 0 1", drop_err, leak_req, leak_floor_out);
        end
        $display("leak floor 0: drop=%b", drop_err);
        leakage = 1'b0;
        tick();
        checks++;
        if (drop_err !== 1'b0) begin
            errors++;
            $display("FAIL leak_floor0_pulse: got %b expected 0", drop_err);
        end
    endtask

    task automatic test_invalid();
        logic [15:0] bad [3];
        bad[0] = 16'hA123;
        bad[1] = 16'h0000;
        bad[2] = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            license_plate = bad[i];
            in_mode = 1'b1;
            out_mode = (i == 2);
            tick();
            checks++;
            if (drop_err !== 1'b1 || queue_count !== 3'd3) begin
                errors++;
                $display("FAIL invalid_%0d: drop %b count %0d expected 1 3", i, drop_err, queue_count);
            end
            $display("invalid: plate=%h both=%b drop=%b", bad[i], (i == 2), drop_err);
            in_mode = 1'b0;
            out_mode = 1'b0;
            tick();
        end
    endtask

    task automatic test_timeout();
        int gap;
        ctrl_ready = 1'b1;
        tick();
        checks++;
        if (in_mode_internal !== 1'b0) begin
            errors++;
            $display("FAIL timeout_exit: got %b expected 0", in_mode_internal);
        end
        tick();
        checks++;
        if (in_mode_internal !== 1'b1 || license_plate_internal !== 16'h9706 || queue_count !== 3'd2) begin
            errors++;
            $display("FAIL timeout_issue: in %b plate %h count %0d expected 1 9706 2",
                     in_mode_internal, license_plate_internal, queue_count);
        end
        gap = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (in_mode_internal || out_mode_internal) begin
                gap = k;
                break;
            end
        end
        checks++;
        if (gap < 16 || gap > 17) begin
            errors++;
            $display("FAIL timeout_gap: got %0d cycles expected 16..17", gap);
        end
        checks++;
        if (in_mode_internal !== 1'b1 || license_plate_internal !== 16'h2666 || queue_count !== 3'd1) begin
            errors++;
            $display("FAIL timeout_next: in %b plate %h count %0d expected 1 2666 1",
                     in_mode_internal, license_plate_internal, queue_count);
        end
        $display("timeout: gap=%0d next plate=%h", gap, license_plate_internal);
    endtask

    task automatic test_reset_mid_wait();
        reset = 1'b0;
        tick();
        checks++;
        if ({in_mode_internal, out_mode_internal, leak_req, queue_full, drop_err} !== 5'b0 ||
            license_plate_internal !== 16'h0 || leak_floor_out !== 3'd0 || queue_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_wait: in %b out %b plate %h floor %0d count %0d expected all 0",
                     in_mode_internal, out_mode_internal, license_plate_internal, leak_floor_out, queue_count);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (queue_count !== 3'd0 || in_mode_internal !== 1'b0 || out_mode_internal !== 1'b0) begin
            errors++;
            $display("FAIL reset_lost_queue: count %0d in %b out %b expected 0 0 0",
                     queue_count, in_mode_internal, out_mode_internal);
        end
        $display("reset mid wait: count=%0d", queue_count);
    endtask

    task automatic test_leak_blocks_pop();
        license_plate = 16'h1111;
        in_mode = 1'b1;
        tick();
        checks++;
        if (queue_count !== 3'd1 || in_mode_internal !== 1'b0) begin
            errors++;
            $display("FAIL block_enqueue: count %0d in %b expected 1 0", queue_count, in_mode_internal);
        end
        in_mode = 1'b0;
        leakage = 1'b1;
        leakage_floor = 3'd3;
        tick();
        checks++;
        if (leak_req !== 1'b1 || leak_floor_out !== 3'd3 || in_mode_internal !== 1'b0 || queue_count !== 3'd1) begin
            errors++;
            $display("FAIL block_pop: req %b floor %0d in %b count %0d expected 1 3 0 1",
                     leak_req, leak_floor_out, in_mode_internal, queue_count);
        end
        tick();
        checks++;
        if (in_mode_internal !== 1'b1 || license_plate_internal !== 16'h1111 ||
            leak_req !== 1'b0 || queue_count !== 3'd0) begin
            errors++;
            $display("FAIL block_then_issue: in %b plate %h req %b count %0d expected 1 1111 0 0",
                     in_mode_internal, license_plate_internal, leak_req, queue_count);
        end
        $display("leak blocks pop: issued plate=%h", license_plate_internal);
        leakage = 1'b0;
        ctrl_ready = 1'b0;
        tick();
        ctrl_ready = 1'b1;
        tick();
        license_plate = 16'h4321;
        out_mode = 1'b1;
        tick();
        checks++;
        if (queue_count !== 3'd1 || out_mode_internal !== 1'b0) begin
            errors++;
            $display("FAIL latency_enqueue: count %0d out %b expected 1 0", queue_count, out_mode_internal);
        end
        out_mode = 1'b0;
        tick();
        checks++;
        if (out_mode_internal !== 1'b1 || in_mode_internal !== 1'b0 ||
            license_plate_internal !== 16'h4321 || queue_count !== 3'd0) begin
            errors++;
            $display("FAIL latency_issue: out %b in %b plate %h count %0d expected 1 0 4321 0",
                     out_mode_internal, in_mode_internal, license_plate_internal, queue_count);
        end
        $display("min latency: out issue plate=%h", license_plate_internal);
    endtask

    task automatic test_back_to_back();
        ctrl_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            license_plate = fill_b[i];
            in_mode = 1'b1;
            tick();
            in_mode = 1'b0;
            tick();
        end
        checks++;
        if (queue_count !== 3'd4 || queue_full !== 1'b1) begin
            errors++;
            $display("FAIL b2b_fill: count %0d full %b expected 4 1", queue_count, queue_full);
        end
        ctrl_ready = 1'b1;
        tick();
        license_plate = 16'h1005;
        in_mode = 1'b1;
        tick();
        checks++;
        if (drop_err !== 1'b0 || queue_count !== 3'd4 || queue_full !== 1'b1 ||
            in_mode_internal !== 1'b1 || license_plate_internal !== 16'h1001) begin
            errors++;
            $display("FAIL full_push_pop: drop %b count %0d full %b in %b plate %h expected 0 4 1 1 1001",
                     drop_err, queue_count, queue_full, in_mode_internal, license_plate_internal);
        end
        $display("full push+pop: count=%0d issued=%h", queue_count, license_plate_internal);
        in_mode = 1'b0;
        ctrl_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_dispatch();
        test_hold_out();
        test_leak_wait();
        test_invalid();
        test_timeout();
        test_reset_mid_wait();
        test_leak_blocks_pop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
